// File: rtl/dmem_arb_pkg.sv
// Shared constants and FSM state encoding for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int PERF_W = 32;

  typedef enum logic {
    CPU_PRI    = 1'b0,
    SCAN_BURST = 1'b1
  } arb_state_t;
endpackage

// File: rtl/dmem_arb_satcnt.sv
// Saturating up-counter with synchronous clear; clear dominates increment.
module dmem_arb_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// CPU / scan-engine arbiter for a single-port async-read data memory.
// Optional performance counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [PERF_W-1:0] perf_c_stall,
  output logic [PERF_W-1:0] perf_s_gnt
);
  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             starve;
  logic             burst_done;

  // Grants are combinational so an access completes in its request cycle.
  always_comb begin
    c_gnt = 1'b0;
    s_gnt = 1'b0;
    if (!rst) begin
      if (state == CPU_PRI) begin
        c_gnt = c_req;
        s_gnt = s_req & ~c_req;
      end else begin
        s_gnt = s_req;
        c_gnt = c_req & ~s_req;
      end
    end
  end

  assign c_stall = c_req & ~c_gnt;
  assign rdata   = m_rdata;

  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_rd    = ~c_we;
      m_wr    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (s_gnt) begin
      m_rd    = ~s_we;
      m_wr    = s_we;
      m_addr  = s_addr;
      m_wdata = s_wdata;
    end
  end

  assign starve = (state == CPU_PRI) & c_req & s_req &
                  (wait_cnt == CNT_W'(STARVE_MAX - 1));
  assign burst_done = (state == SCAN_BURST) &
                      (~s_req | (s_gnt & (burst_cnt == CNT_W'(BURST_MAX - 1))));

  always_ff @(posedge clk) begin
    if (rst)
      state <= CPU_PRI;
    else if (starve)
      state <= SCAN_BURST;
    else if (burst_done)
      state <= CPU_PRI;
  end

  // wait_cnt is held at zero outside CPU_PRI so it is clean on re-entry.
  dmem_arb_satcnt #(.W(CNT_W)) u_wait_cnt (
    .clk (clk),
    .clr (rst | (state != CPU_PRI) | ~s_req | s_gnt | starve),
    .inc (c_req & s_req),
    .cnt (wait_cnt)
  );

  dmem_arb_satcnt #(.W(CNT_W)) u_burst_cnt (
    .clk (clk),
    .clr (rst | (state == CPU_PRI)),
    .inc (s_gnt),
    .cnt (burst_cnt)
  );

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_satcnt #(.W(PERF_W)) u_perf_c_stall (
    .clk (clk),
    .clr (rst),
    .inc (c_stall),
    .cnt (perf_c_stall)
  );

  dmem_arb_satcnt #(.W(PERF_W)) u_perf_s_gnt (
    .clk (clk),
    .clr (rst),
    .inc (s_gnt),
    .cnt (perf_s_gnt)
  );
`else
  assign perf_c_stall = '0;
  assign perf_s_gnt   = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural async-read memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_req, c_we, s_req, s_we;
  logic [ADDR_W-1:0] c_addr, s_addr;
  logic [DATA_W-1:0] c_wdata, s_wdata;
  logic              c_gnt, c_stall, s_gnt;
  logic [DATA_W-1:0] rdata;
  logic              m_rd, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [PERF_W-1:0] perf_c_stall, perf_s_gnt;

  logic [DATA_W-1:0] mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        cg;
    logic        sg;
    logic        st;
    logic        rchk;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

`ifdef DMEM_ARB_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd8;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (m_wr) mem[m_addr] <= m_wdata;
  assign m_rdata = mem[m_addr];

  dmem_arbiter #(.STARVE_MAX(8), .BURST_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .c_req        (c_req),
    .c_we         (c_we),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_gnt        (c_gnt),
    .c_stall      (c_stall),
    .s_req        (s_req),
    .s_we         (s_we),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_gnt        (s_gnt),
    .rdata        (rdata),
    .m_rd         (m_rd),
    .m_wr         (m_wr),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .perf_c_stall (perf_c_stall),
    .perf_s_gnt   (perf_s_gnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; push the expectation, then compare mid-cycle.
  task automatic expect_cycle(input string tag, input logic cg, input logic sg,
                              input logic rchk, input logic [31:0] rd);
    exp_t e;
    e.tag = tag; e.cg = cg; e.sg = sg; e.st = c_req & ~cg; e.rchk = rchk; e.rd = rd;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_c_gnt"},   32'(c_gnt),   32'(e.cg));
    check({e.tag, "_s_gnt"},   32'(s_gnt),   32'(e.sg));
    check({e.tag, "_c_stall"}, 32'(c_stall), 32'(e.st));
    check({e.tag, "_mutex"},   32'(c_gnt & s_gnt), 32'd0);
    if (e.rchk) check({e.tag, "_rdata"}, rdata, e.rd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    c_addr = '0; c_wdata = '0; s_we = 1'b0; s_addr = '0; s_wdata = '0;

    // Reset blocks a pending CPU write.
    rst = 1'b1; c_req = 1'b1; c_we = 1'b1; s_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_m_wr",  32'(m_wr),  32'd0);
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_s_gnt", 32'(s_gnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_perf_c_stall", perf_c_stall, 32'd0);
    check("rst_perf_s_gnt",   perf_s_gnt,   32'd0);
    check("rst_state",        32'(dut.state), 32'(CPU_PRI));
    c_we = 1'b0;
    expect_cycle("post_rst", 1'b1, 1'b0, 1'b0, 32'h0);

    // CPU-only write then read back.
    do_reset();
    c_req = 1'b1; c_we = 1'b1; c_addr = 7'h05; c_wdata = 32'hDEADBEEF;
    expect_cycle("cpu_wr", 1'b1, 1'b0, 1'b0, 32'h0);
    c_we = 1'b0; c_wdata = '0;
    expect_cycle("cpu_rd", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);

    // Both requesting continuously: 8 CPU / 4 scan alternation.
    do_reset();
    c_req = 1'b1; c_addr = 7'h10; s_req = 1'b1; s_addr = 7'h20;
    for (int i = 0; i < 24; i++) begin
      logic cg;
      cg = (i < 8) || (i >= 12 && i < 20);
      expect_cycle($sformatf("both_c%0d", i), cg, ~cg, 1'b0, 32'h0);
    end
    check("perf_c_stall", perf_c_stall, PERF_EXP);
    check("perf_s_gnt",   perf_s_gnt,   PERF_EXP);

    // Scan drops out after two burst grants.
    do_reset();
    c_req = 1'b1; s_req = 1'b1;
    for (int i = 0; i < 8; i++) expect_cycle("early_cpu", 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) expect_cycle("early_burst", 1'b0, 1'b1, 1'b0, 32'h0);
    s_req = 1'b0;
    expect_cycle("early_exit", 1'b1, 1'b0, 1'b0, 32'h0);
    check("early_state", 32'(dut.state), 32'(CPU_PRI));
    check("early_wait",  32'(dut.wait_cnt), 32'd0);

    // Scan only: unlimited grants, no state change.
    do_reset();
    s_req = 1'b1; s_we = 1'b1; s_addr = 7'h33; s_wdata = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      expect_cycle($sformatf("scan_only_c%0d", i), 1'b0, 1'b1, 1'b0, 32'h0);
      check("scan_only_state", 32'(dut.state), 32'(CPU_PRI));
    end
    check("scan_mem_write", mem[7'h33], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: scan-wait cycles, with CPU holding the memory, before scan engine gets priority; legal range 2..255.
REQ-002 SHALL have parameter BURST_MAX, default 4: maximum consecutive priority grants to the scan engine; legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port c_req  input  1  CPU MEM-stage access request.
REQ-006 SHALL have port c_we  input  1  CPU write enable (0 = read).
REQ-007 SHALL have port c_addr  input  7  CPU word address.
REQ-008 SHALL have port c_wdata  input  32  CPU write data.
REQ-009 SHALL have port c_gnt  output  1  CPU access performed this cycle.
REQ-010 SHALL have port c_stall  output  1  equals c_req AND NOT c_gnt; feeds the pipeline stall/hold logic.
REQ-011 SHALL have port s_req  input  1  scan-engine access request.
REQ-012 SHALL have port s_we  input  1  scan-engine write enable (0 = read).
REQ-013 SHALL have port s_addr  input  7  scan-engine word address.
REQ-014 SHALL have port s_wdata  input  32  scan-engine write data.
REQ-015 SHALL have port s_gnt  output  1  scan-engine access performed this cycle.
REQ-016 SHALL have port rdata  output  32  equals m_rdata; valid for the granted reader in the grant cycle.
REQ-017 SHALL have ports m_rd, m_wr (output, 1), m_addr (output, 7), m_wdata (output, 32), m_rdata (input, 32), connecting to the single-port asynchronous-read data memory.
REQ-018 SHALL have ports perf_c_stall and perf_s_gnt  output  32  performance counters (see REQ-030).

Function
REQ-019 SHALL compute grants combinationally from requests and the registered state, with zero-cycle latency: a granted request completes in the same cycle; the requester holds req/we/addr/wdata stable until granted.
REQ-020 SHALL drive m_* from the granted port; m_rd = granted AND NOT we, m_wr = granted AND we; with no grant, m_rd = m_wr = 0 and m_addr = m_wdata = 0.
REQ-021 SHALL never assert c_gnt and s_gnt together.
REQ-022 SHALL implement a two-state FSM, CPU_PRI and SCAN_BURST.
REQ-023 In CPU_PRI: c_gnt = c_req; s_gnt = s_req AND NOT c_req.
REQ-024 In CPU_PRI, wait_cnt SHALL increment (saturating) each cycle with s_req AND c_req, and clear when s_gnt is asserted or s_req is 0.
REQ-025 In CPU_PRI, when c_req, s_req and wait_cnt == STARVE_MAX-1 at an edge, the FSM SHALL move to SCAN_BURST, clearing wait_cnt and burst_cnt.
REQ-026 In SCAN_BURST: s_gnt = s_req; c_gnt = c_req AND NOT s_req; burst_cnt increments on each s_gnt.
REQ-027 SCAN_BURST SHALL return to CPU_PRI at the edge where s_gnt is asserted and burst_cnt == BURST_MAX-1, or at any edge where s_req is 0; wait_cnt is 0 on entry.
REQ-028 Scan requests with c_req low SHALL be granted every cycle without limit, in either state.

Reset
REQ-029 While rst is high: c_gnt, s_gnt, m_rd and m_wr SHALL be 0 regardless of requests. The next state SHALL be CPU_PRI with wait_cnt, burst_cnt and perf counters at 0. Reset mid-burst SHALL abandon the burst.

Configuration
REQ-030 With DMEM_ARB_PERF_EN defined, perf_c_stall SHALL count cycles with c_stall = 1 and perf_s_gnt SHALL count cycles with s_gnt = 1; both saturate at 32'hFFFFFFFF. Without the macro, both outputs SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the FSM state enum and the ADDR_W = 7 and DATA_W = 32 constants.
REQ-032 The saturating counter (wait_cnt, burst_cnt, perf counters) SHALL be one sub-module, dmem_arb_satcnt, parameterised on width.

Verification
REQ-033 Reset case: rst = 1 with c_req = c_we = 1 gives m_wr = 0 and c_gnt = 0. In the first cycle after release, c_req gives c_gnt = 1 in that cycle.
REQ-034 CPU only: write 32'hDEADBEEF to address 7'h05, then read 7'h05. Required: rdata = 32'hDEADBEEF in the read's grant cycle, and c_stall = 0 throughout.
REQ-035 Both requests held from cycle 0 (defaults). Required: c_gnt in cycles 0-7, s_gnt in 8-11, c_gnt in 12-19, s_gnt in 20-23; c_stall = 1 exactly in cycles 8-11 and 20-23.
REQ-036 Early burst exit: s_req drops after 2 burst grants. Required: c_gnt in that same cycle, state CPU_PRI on the next cycle, wait_cnt = 0.
REQ-037 Scan only for 20 cycles: s_gnt = 1 in all 20 cycles; the FSM stays in CPU_PRI.
REQ-038 Counters over the REQ-035 run, cycles 0-23: with DMEM_ARB_PERF_EN, perf_c_stall = 8 and perf_s_gnt = 8; without the macro, both read 0.
